pushbutton_avalon_responder: RTL and testbench

Avalon-MM responder peripheral for the board pushbuttons, attached to the HPS lightweight bridge. It sits between the raw KEY pins and the interconnect. It synchronizes and debounces each button, captures press edges, counts presses, and raises a maskable level interrupt. The HPS initiator sees four 32-bit registers with a fixed read latency of one cycle.

---
 rtl/pushbutton_avalon_responder.sv | 179 +++++++++++++++++
 tb/tb_pushbutton_avalon_responder.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/pushbutton_avalon_responder.sv
`default_nettype none
// ============================================================================
// Module   : pushbutton_avalon_responder
// Purpose  : Avalon-MM responder for the board pushbuttons. Each button is
//            synchronized, debounced and edge-detected. Press edges are
//            captured, counted and can raise a maskable level interrupt.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk_clk            in   1      system clock, rising edge
//   reset_reset_n      in   1      asynchronous active-low reset
//   avs_address        in   2      register word address
//   avs_read           in   1      read request
//   avs_write          in   1      write request
//   avs_writedata      in   32     write data
//   avs_readdata       out  32     read data, valid with avs_readdatavalid
//   avs_readdatavalid  out  1      pulse one cycle after an accepted read
//   avs_waitrequest    out  1      always 0
//   buttons_n          in   WIDTH  raw active-low button pins
//   irq                out  1      level interrupt, active-high
// Register map: 0 DATA (RO), 1 MASK (RW), 2 EDGECAP (W1C), 3 COUNT (write clears)
// ============================================================================
module pushbutton_avalon_responder #(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic             clk_clk,
    input  logic             reset_reset_n,
    input  logic [1:0]       avs_address,
    input  logic             avs_read,
    input  logic             avs_write,
    input  logic [31:0]      avs_writedata,
    output logic [31:0]      avs_readdata,
    output logic             avs_readdatavalid,
    output logic             avs_waitrequest,
    input  logic [WIDTH-1:0] buttons_n,
    output logic             irq
);

    localparam int             CNT_W      = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] c_TERM    = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_TERM_M1 = CNT_W'(DEBOUNCE_CYCLES - 2);

    // ------------------------------------------------------------------
    // Input path: synchronizer, debounce, press-edge detect
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] sync1_q, sync2_q;
    logic [WIDTH-1:0] raw;
    logic [WIDTH-1:0] raw_prev_q;
    logic [WIDTH-1:0] settle;       // counter is about to reach terminal
    logic [WIDTH-1:0] stable_q, stable_d;
    logic [WIDTH-1:0] stable_dly_q;
    logic [WIDTH-1:0] press;

    assign raw = ~sync2_q;

    for (genvar i = 0; i < WIDTH; i++) begin : g_debounce
        logic [CNT_W-1:0] cnt_q, cnt_d;

        always_comb begin
            cnt_d = cnt_q;
            if (raw[i] != raw_prev_q[i]) begin
                cnt_d = '0;
            end else if (cnt_q != c_TERM) begin
                cnt_d = cnt_q + 1'b1;
            end
        end

        // stable takes raw on the same edge the counter lands on terminal
        assign settle[i] = (raw[i] == raw_prev_q[i]) && (cnt_q == c_TERM_M1);

        always_ff @(posedge clk_clk or negedge reset_reset_n) begin
            if (!reset_reset_n) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_d;
            end
        end
    end

    assign stable_d = (stable_q & ~settle) | (raw & settle);
    assign press    = stable_q & ~stable_dly_q;

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            sync1_q      <= '1;
            sync2_q      <= '1;
            raw_prev_q   <= '0;
            stable_q     <= '0;
            stable_dly_q <= '0;
        end else begin
            sync1_q      <= buttons_n;
            sync2_q      <= sync1_q;
            raw_prev_q   <= raw;
            stable_q     <= stable_d;
            stable_dly_q <= stable_q;
        end
    end

    // ------------------------------------------------------------------
    // Register file
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [WIDTH-1:0] edge_q, edge_d;
    logic [15:0]      count_q, count_d;
    logic [4:0]       press_cnt;
    logic [16:0]      count_sum;
    logic             irq_q;
    logic [31:0]      rdata_q, rdata_d;
    logic             rdv_q;
    logic             wr_mask, wr_edge, wr_count, rd_accept;
    logic             unused_wdata;

    // A simultaneous read and write performs only the write.
    assign rd_accept = avs_read & ~avs_write;
    assign wr_mask   = avs_write && (avs_address == 2'd1);
    assign wr_edge   = avs_write && (avs_address == 2'd2);
    assign wr_count  = avs_write && (avs_address == 2'd3);

    // Upper write-data bits have no storage behind them.
    assign unused_wdata = ^avs_writedata;

    always_comb begin
        press_cnt = '0;
        for (int i = 0; i < WIDTH; i++) begin
            press_cnt = press_cnt + 5'(press[i]);
        end
    end

    always_comb begin
        mask_d = wr_mask ? avs_writedata[WIDTH-1:0] : mask_q;

        // W1C with a new press taking priority over the clear
        edge_d = edge_q;
        if (wr_edge) begin
            edge_d = edge_q & ~avs_writedata[WIDTH-1:0];
        end
        edge_d = edge_d | press;

        // A clear and a press together leave just the press count
        count_sum = {1'b0, (wr_count ? 16'h0000 : count_q)} + 17'(press_cnt);
        count_d   = count_sum[16] ? 16'hFFFF : count_sum[15:0];

        rdata_d = '0;
        if (rd_accept) begin
            case (avs_address)
                2'd0:    rdata_d = 32'(stable_q);
                2'd1:    rdata_d = 32'(mask_q);
                2'd2:    rdata_d = 32'(edge_q);
                default: rdata_d = 32'(count_q);
            endcase
        end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            mask_q  <= '0;
            edge_q  <= '0;
            count_q <= '0;
            irq_q   <= 1'b0;
            rdata_q <= '0;
            rdv_q   <= 1'b0;
        end else begin
            mask_q  <= mask_d;
            edge_q  <= edge_d;
            count_q <= count_d;
            irq_q   <= |(edge_q & mask_q);
            rdata_q <= rdata_d;
            rdv_q   <= rd_accept;
        end
    end

    assign avs_readdata      = rdata_q;
    assign avs_readdatavalid = rdv_q;
    assign avs_waitrequest   = 1'b0;
    assign irq               = irq_q;

endmodule
`default_nettype wire

// File: tb/tb_pushbutton_avalon_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_pushbutton_avalon_responder
// Purpose  : Directed self-checking bench for pushbutton_avalon_responder
//            with WIDTH=4 and DEBOUNCE_CYCLES=4.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pushbutton_avalon_responder;

    localparam int W = 4;

    logic         clk_clk = 1'b0;
    logic         reset_reset_n;
    logic [1:0]   avs_address;
    logic         avs_read;
    logic         avs_write;
    logic [31:0]  avs_writedata;
    logic [31:0]  avs_readdata;
    logic         avs_readdatavalid;
    logic         avs_waitrequest;
    logic [W-1:0] buttons_n;
    logic         irq;

    int n_cmp = 0;
    int n_bad = 0;

    pushbutton_avalon_responder #(
        .WIDTH           (W),
        .DEBOUNCE_CYCLES (4)
    ) dut (
        .clk_clk           (clk_clk),
        .reset_reset_n     (reset_reset_n),
        .avs_address       (avs_address),
        .avs_read          (avs_read),
        .avs_write         (avs_write),
        .avs_writedata     (avs_writedata),
        .avs_readdata      (avs_readdata),
        .avs_readdatavalid (avs_readdatavalid),
        .avs_waitrequest   (avs_waitrequest),
        .buttons_n         (buttons_n),
        .irq               (irq)
    );

    always #5 clk_clk = ~clk_clk;

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic tick();
        @(posedge clk_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string tag);
        avs_address = a;
        avs_read    = 1'b1;
        tick();
        avs_read    = 1'b0;
        chk($sformatf("%s_rdv", tag), 32'(avs_readdatavalid), 32'd1);
        chk(tag, avs_readdata, exp);
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        avs_address   = a;
        avs_writedata = d;
        avs_write     = 1'b1;
        tick();
        avs_write     = 1'b0;
    endtask

    initial begin
        reset_reset_n = 1'b0;
        avs_address   = '0;
        avs_read      = 1'b0;
        avs_write     = 1'b0;
        avs_writedata = '0;
        buttons_n     = '1;
        tick();
        tick();
        reset_reset_n = 1'b1;
        tick();

        // Reset state
        chk("rst_irq", 32'(irq), 32'd0);
        chk("rst_rdv", 32'(avs_readdatavalid), 32'd0);
        chk("rst_rdata", avs_readdata, 32'd0);
        chk("waitreq", 32'(avs_waitrequest), 32'd0);

        // Back-to-back reads of all four registers
        avs_read = 1'b1;
        for (int a = 0; a < 4; a++) begin
            avs_address = 2'(a);
            tick();
            chk($sformatf("b2b%0d_rdv", a), 32'(avs_readdatavalid), 32'd1);
            chk($sformatf("b2b%0d_data", a), avs_readdata, 32'd0);
        end
        avs_read = 1'b0;
        tick();
        chk("b2b_end_rdv", 32'(avs_readdatavalid), 32'd0);

        // Three-cycle glitch on button 0 must be rejected
        buttons_n = 4'b1110;
        repeat (3) tick();
        buttons_n = 4'b1111;
        repeat (8) tick();
        rd(2'd0, 32'h0, "glitch_data");
        rd(2'd2, 32'h0, "glitch_edge");
        rd(2'd3, 32'h0, "glitch_count");

        // Buttons 1 and 3 pressed
        buttons_n = 4'b0101;
        repeat (10) tick();
        rd(2'd0, 32'hA, "press_data");
        rd(2'd2, 32'hA, "press_edge");
        rd(2'd3, 32'h2, "press_count");
        chk("press_irq_masked", 32'(irq), 32'd0);

        // DATA is read-only
        wr(2'd0, 32'hFFFF_FFFF);
        rd(2'd0, 32'hA, "data_ro");

        // MASK write (upper bits dropped); irq follows one cycle later
        wr(2'd1, 32'hFFFF_FFF2);
        chk("mask_irq_same", 32'(irq), 32'd0);
        tick();
        chk("mask_irq_next", 32'(irq), 32'd1);
        rd(2'd1, 32'h2, "mask_rd");

        // Release button 1, then re-press and clear bit 1 during the press pulse
        buttons_n = 4'b0111;
        repeat (10) tick();
        rd(2'd0, 32'h8, "rel_data");
        buttons_n = 4'b0101;
        repeat (6) tick();  // now inside the press cycle of button 1
        wr(2'd2, 32'h2);
        chk("setwins_irq", 32'(irq), 32'd1);
        rd(2'd2, 32'hA, "setwins_edge");
        chk("setwins_irq2", 32'(irq), 32'd1);
        rd(2'd3, 32'h3, "repress_count");

        // Plain W1C clear drops irq one cycle after the bit clears
        wr(2'd2, 32'h2);
        chk("clr_irq_same", 32'(irq), 32'd1);
        tick();
        chk("clr_irq_next", 32'(irq), 32'd0);
        rd(2'd2, 32'h8, "clr_edge");

        // COUNT saturation
        force dut.count_q = 16'hFFFE;
        tick();
        release dut.count_q;
        rd(2'd3, 32'hFFFE, "preload");
        buttons_n = 4'b1111;
        repeat (10) tick();
        rd(2'd3, 32'hFFFE, "release_nocount");
        buttons_n = 4'b1010;
        repeat (10) tick();
        rd(2'd3, 32'hFFFF, "sat_two");
        rd(2'd0, 32'h5, "two_data");
        buttons_n = 4'b1111;
        repeat (10) tick();
        buttons_n = 4'b1101;
        repeat (10) tick();
        rd(2'd3, 32'hFFFF, "sat_hold");
        wr(2'd3, 32'h1234_5678);
        rd(2'd3, 32'h0, "count_clr");
        rd(2'd2, 32'hF, "edge_all");

        // Simultaneous read and write: write done, no readdatavalid
        avs_address   = 2'd1;
        avs_writedata = 32'h5;
        avs_read      = 1'b1;
        avs_write     = 1'b1;
        tick();
        avs_read      = 1'b0;
        avs_write     = 1'b0;
        chk("rdwr_no_rdv", 32'(avs_readdatavalid), 32'd0);
        rd(2'd1, 32'h5, "rdwr_mask");
        chk("irq_before_rst", 32'(irq), 32'd1);

        // Reset in the cycle after a read request aborts it
        buttons_n = 4'b1111;
        repeat (10) tick();
        avs_address = 2'd2;
        avs_read    = 1'b1;
        tick();
        avs_read      = 1'b0;
        reset_reset_n = 1'b0;
        #1;
        chk("arst_rdv", 32'(avs_readdatavalid), 32'd0);
        chk("arst_irq", 32'(irq), 32'd0);
        tick();
        tick();
        reset_reset_n = 1'b1;
        tick();
        chk("post_rst_rdv", 32'(avs_readdatavalid), 32'd0);
        chk("post_rst_irq", 32'(irq), 32'd0);
        for (int a = 0; a < 4; a++) begin
            rd(2'(a), 32'h0, $sformatf("post_rst_reg%0d", a));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
